// File: rtl/timer_scheduler_pkg.sv
// Shared types and limits for the timer_scheduler cluster.
package timer_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sched_state_t;

    localparam int CW_DEFAULT = 16;
    localparam int N_REQ_MAX  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping
// modulo N_REQ. Reusable by any shared-resource block.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic                     valid
);

    localparam int PW = $clog2(N_REQ);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        // Walk from the farthest offset down so the nearest hit is written last.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_REQ]) begin
                sel   = PW'((int'(ptr) + i) % N_REQ);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// One shared up-counting delay timer, granted round-robin to N_REQ requesters,
// returning a single-cycle done pulse to the granted requester on expiry.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CW    = CW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] delay,
    input  logic                abort,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    output logic [CW-1:0]       count
);

    localparam int PW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n_req
        $error("timer_scheduler: N_REQ must be in 2..N_REQ_MAX");
    end

    sched_state_t   state, state_n;
    logic [PW-1:0]  ptr, ptr_n;
    logic [PW-1:0]  sel_q, sel_n;
    logic [PW-1:0]  sel_after;
    logic [PW-1:0]  arb_sel;
    logic           arb_valid;
    logic [CW-1:0]  trig, trig_n;
    logic [CW-1:0]  count_n;
    logic [N_REQ-1:0] gnt_n, done_n;
    logic           busy_n;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req  (req),
        .ptr  (ptr),
        .sel  (arb_sel),
        .valid(arb_valid)
    );

    // Pointer moves past the served requester once its service ends.
    assign sel_after = (sel_q == PW'(N_REQ - 1)) ? '0 : sel_q + PW'(1);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel_q;
        trig_n  = trig;
        gnt_n   = gnt;
        done_n  = '0;
        count_n = count;
        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_n = RUN;
                    sel_n   = arb_sel;
                    trig_n  = delay[int'(arb_sel)*CW +: CW];
                    gnt_n   = N_REQ'(1) << arb_sel;
                    count_n = '0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    count_n = '0;
                    ptr_n   = sel_after;
                end else if (count == trig) begin
                    state_n = DONE;
                    done_n  = gnt;
                    count_n = '0;
                end else begin
                    count_n = count + CW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                gnt_n   = '0;
                ptr_n   = sel_after;
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
                count_n = '0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            sel_q <= '0;
            trig  <= '0;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel_q <= sel_n;
            trig  <= trig_n;
            gnt   <= gnt_n;
            done  <= done_n;
            busy  <= busy_n;
            count <= count_n;
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: cycle-timeline model plus directed scenarios.
module tb_timer_scheduler;

    localparam int N  = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] delay = '0;
    logic            abort = 1'b0;
    logic [N-1:0]    gnt, done;
    logic            busy;
    logic [CW-1:0]   count;

    timer_scheduler #(.N_REQ(N), .CW(CW)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .delay(delay),
        .abort(abort),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    int t0       = 0;
    int done_cyc[$];
    int done_idx[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
    endtask

    // Timeline model: a service granted in cycle s with delay d shows count
    // 0..d in cycles s..s+d, done in s+d+1, then one idle cycle.
    bit           started = 0;
    bit           m_busy  = 0;
    bit           found;
    int           m_sel, m_start, m_d, m_ptr, pos, idx;
    logic [N-1:0] exp_gnt, exp_done;
    logic         exp_busy;
    logic [CW-1:0] exp_count;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_ptr  = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req[idx]) begin
                    found   = 1;
                    m_busy  = 1;
                    m_sel   = idx;
                    m_start = cyc + 1;
                    m_d     = int'(delay[idx*CW +: CW]);
                end
            end
        end else begin
            pos = cyc - m_start;
            if ((pos <= m_d && abort) || pos == m_d + 1) begin
                m_busy = 0;
                m_ptr  = (m_sel + 1) % N;
            end
        end
        cyc = cyc + 1;
        exp_gnt   = '0;
        exp_done  = '0;
        exp_busy  = m_busy;
        exp_count = '0;
        if (m_busy) begin
            pos     = cyc - m_start;
            exp_gnt = N'(1) << m_sel;
            if (pos <= m_d) exp_count = CW'(pos);
            else exp_done = exp_gnt;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            check("gnt", gnt, exp_gnt);
            check("done", done, exp_done);
            check("busy", busy, exp_busy);
            check("count", count, exp_count);
            if (done != '0) begin
                done_cyc.push_back(cyc - t0);
                for (int k = 0; k < N; k++) if (done[k]) done_idx.push_back(k);
            end
        end
    end

    // One cycle forward; a requester drops req in the cycle it sees done.
    task automatic step();
        @(posedge clk);
        #2;
        if ((done & req) != '0) req = req & ~done;
    endtask

    task automatic goto(int rel);
        while (cyc < t0 + rel) step();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        abort = 1'b0;
        req   = '0;
        step();
        rst = 1'b0;
        step();
        done_cyc.delete();
        done_idx.delete();
        t0 = cyc;
    endtask

    task automatic check_ev(string name, int k, int rel, int who);
        check({name, "_present"}, 64'(done_cyc.size() > k), 64'(1));
        if (done_cyc.size() > k) begin
            check({name, "_cyc"}, 64'(done_cyc[k]), 64'(rel));
            check({name, "_idx"}, 64'(done_idx[k]), 64'(who));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);

        // Single request, delay 5.
        do_reset();
        req = 4'b0001;
        delay[0*CW +: CW] = 16'd5;
        goto(3);
        check("s1_count_c3", count, 2);
        goto(7);
        check("s1_done_c7", done, 4'b0001);
        goto(8);
        check("s1_busy_c8", busy, 0);
        goto(10);
        check("s1_ndone", 64'(done_cyc.size()), 1);
        check_ev("s1_ev0", 0, 7, 0);

        // Round-robin, all four with delay 2.
        do_reset();
        for (int i = 0; i < N; i++) delay[i*CW +: CW] = 16'd2;
        req = 4'b1111;
        goto(6);
        check("s2_gnt_c6", gnt, 4'b0010);
        goto(22);
        check("s2_ndone", 64'(done_cyc.size()), 4);
        check_ev("s2_ev0", 0, 4, 0);
        check_ev("s2_ev1", 1, 9, 1);
        check_ev("s2_ev2", 2, 14, 2);
        check_ev("s2_ev3", 3, 19, 3);

        // Zero delay on requester 2.
        do_reset();
        req = 4'b0100;
        delay[2*CW +: CW] = 16'd0;
        goto(1);
        check("s3_gnt_c1", gnt, 4'b0100);
        check("s3_count_c1", count, 0);
        goto(4);
        check_ev("s3_ev0", 0, 2, 2);

        // Abort long service on 1; pending 2 is next, late delay change ignored.
        do_reset();
        delay[1*CW +: CW] = 16'd100;
        delay[2*CW +: CW] = 16'd1;
        req = 4'b0110;
        goto(10);
        abort = 1'b1;
        goto(11);
        abort  = 1'b0;
        req[1] = 1'b0;
        check("s4_gnt_c11", gnt, 0);
        check("s4_busy_c11", busy, 0);
        goto(12);
        check("s4_gnt_c12", gnt, 4'b0100);
        delay[2*CW +: CW] = 16'd50;
        goto(17);
        check("s4_ndone", 64'(done_cyc.size()), 1);
        check_ev("s4_ev0", 0, 14, 2);

        // Abort coincident with expiry.
        do_reset();
        req = 4'b0001;
        delay[0*CW +: CW] = 16'd3;
        goto(4);
        check("s5_count_c4", count, 3);
        abort = 1'b1;
        goto(5);
        abort = 1'b0;
        req   = '0;
        check("s5_busy_c5", busy, 0);
        goto(8);
        check("s5_ndone", 64'(done_cyc.size()), 0);

        // Reset mid-RUN, then re-serve requester 3 with req dropped during RUN.
        do_reset();
        req = 4'b1000;
        delay[3*CW +: CW] = 16'd20;
        goto(6);
        rst = 1'b1;
        goto(7);
        rst = 1'b0;
        check("s6_gnt_c7", gnt, 0);
        check("s6_busy_c7", busy, 0);
        check("s6_count_c7", count, 0);
        goto(8);
        check("s6_gnt_c8", gnt, 4'b1000);
        goto(10);
        req = '0;
        goto(31);
        check("s6_ndone", 64'(done_cyc.size()), 1);
        check_ev("s6_ev0", 0, 29, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Shares one 16-bit up-counting delay timer among `N_REQ` requesters.
- Requesters post a delay value. The block grants them round-robin, clears and runs the shared counter, and returns a single-cycle `done` to the granted requester when the delay expires.
- It sits between control FSMs that need timed waits (debounce, pulse spacing, timeouts) and the timing datapath, so only one counter is instantiated per cluster.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `CW`, 16, counter and delay width.

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in N_REQ: request per requester; held high until that requester's `done`.
- `delay` in N_REQ*CW: packed delays; requester i uses bits [i*CW +: CW]; sampled only at grant.
- `abort` in 1: cancel the service in progress.
- `gnt` out N_REQ: one-hot, the requester currently being served.
- `done` out N_REQ: one-hot single-cycle expiry pulse.
- `busy` out 1: high whenever state is not IDLE.
- `count` out CW: current counter value; 0 outside RUN.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, at least one `req` bit high:
  - The arbiter picks the first set bit at or above `ptr`, wrapping modulo N_REQ.
  - Latch `delay[sel]` into `trig`, set `gnt` to onehot(sel), set `count` to 0, go to RUN.
- IDLE, no request: remain in IDLE, outputs stay at reset values.
- RUN:
  - If `abort`: go to IDLE, clear `gnt` and `count`, no `done`, `ptr` becomes sel+1.
  - Else if `count == trig`: go to DONE, set `done` to onehot(sel), clear `count`.
  - Else: `count` increments by 1.
- DONE (one cycle, `done` high): go to IDLE, clear `gnt` and `done`, `ptr` becomes sel+1 modulo N_REQ.
- `abort` is ignored in IDLE and DONE. `abort` takes priority over expiry when both occur in the same cycle.
- Dropping `req` during RUN is ignored: timing completes and `done` is still issued.
- Changing `delay` after grant has no effect.
- `count` never wraps, since it stops at `trig` ≤ 2^CW−1.
- `delay = 0`: expiry on the first RUN cycle.
- Reset values: state IDLE, `ptr` 0, `trig` 0, `gnt` 0, `done` 0, `busy` 0, `count` 0.
- Reset mid-RUN aborts silently, with no `done`.

## Timing
- All outputs are registered.
- Grant latency: `req` seen in IDLE at cycle t gives `gnt` and `busy` high from t+1.
- Expiry: `done` is high in cycle t+2+D for delay D. `gnt` is high for cycles t+1 .. t+2+D.
- One IDLE cycle always follows DONE. Minimum request-to-request spacing is therefore D+3 cycles.
- Requester handshake: on seeing `done` it deasserts `req` by the following (IDLE) cycle. A `req` still high in IDLE is treated as a new request.
- Abort asserted in cycle a gives `gnt` = 0 and `busy` = 0 in cycle a+1.

## Structure
- Package `timer_scheduler_pkg`:
  - state enum `sched_state_t` {IDLE, RUN, DONE}.
  - localparam `CW_DEFAULT` = 16.
  - localparam `N_REQ_MAX` = 8.
- Sub-module `rr_arbiter`:
  - Purely combinational.
  - Inputs: `req` [N_REQ], `ptr` [$clog2(N_REQ)].
  - Outputs: `sel` index and `valid`.
  - Reusable by other shared-resource blocks.
- The counter, `trig` register and FSM stay in the top module.

## Test plan
- Single request: req=4'b0001, delay0=5 at cycle 0 → gnt=0001 at cycles 1–7, `done[0]` only at cycle 7, `count` runs 0..5, `busy` low at cycle 8.
- Round-robin: all four req high, each delay 2, each requester drops req after its done → service order 0,1,2,3; done pulses at cycles 4, 9, 14, 19.
- Zero delay: req[2] with delay 0 → `done[2]` at cycle 2, `count` stays 0.
- Abort: req[1], delay 100, abort at cycle 10 → gnt=0 at cycle 11, no done pulse, the next pending req[2] is granted at cycle 12.
- Abort coincident with expiry: delay 3, abort at cycle 4 → no done, idle at cycle 5.
- Reset mid-RUN: rst at cycle 6 with delay 20 → all outputs zero at cycle 7, ptr=0, no done; req[3] re-served correctly afterwards.
